// File: rtl/parity_rx4_pkg.sv
// Shared types and constants for the 4-bit parity-checked serial receiver.
package parity_rx4_pkg;

  localparam int DATA_W    = 4;
  localparam int FRAME_LEN = 7;
  localparam int BIT_IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rxState_e;

endpackage

// File: rtl/parity_rx4_xor.sv
// Purely combinational even-parity tree over the received data nibble.
module parity4_xor
  import parity_rx4_pkg::*;
(
  input  logic [DATA_W-1:0] i_bits,
  output logic              o_par
);

  // Reduction XOR of all four data bits.
  always_comb begin
    o_par = ^i_bits;
  end

endmodule

// File: rtl/parity_rx4.sv
// Serial receiver for 7-bit frames: start, four data bits LSB first,
// even parity, stop. Flags parity and framing errors and keeps a
// saturating count of errored frames.
module parity_rx4
  import parity_rx4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             rx,
  input  logic             clr_cnt,
  output logic [3:0]       data,
  output logic             valid,
  output logic             par_err,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};

  rxState_e              r_state;
  rxState_e              w_stateNext;
  logic [BIT_IDX_W-1:0]  r_bitIdx;
  logic [BIT_IDX_W-1:0]  w_bitIdxNext;
  logic [DATA_W-1:0]     r_shift;
  logic [DATA_W-1:0]     w_shiftNext;
  logic                  r_par;
  logic                  w_parNext;
  logic                  w_frameDone;

  logic                  w_dataPar;
  logic                  w_parErr;
  logic                  w_frameErr;
  logic [CNT_W-1:0]      w_cntNext;

  logic [DATA_W-1:0]     r_data;
  logic                  r_valid;
  logic                  r_parErr;
  logic                  r_frameErr;
  logic [CNT_W-1:0]      r_errCnt;

  parity4_xor u_parity (
    .i_bits (r_shift),
    .o_par  (w_dataPar)
  );

  // The stop bit is the one being sampled while w_frameDone is high,
  // so the framing check looks at the live line value.
  assign w_parErr   = w_dataPar ^ r_par;
  assign w_frameErr = ~rx;

  // Frame-walking state and datapath registers; only move on strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
      r_par    <= w_parNext;
    end
  end

  // Next-state logic; everything holds unless a sample strobe arrives.
  always_comb begin
    w_stateNext  = r_state;
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_parNext    = r_par;
    w_frameDone  = 1'b0;
    if (sample_en) begin
      case (r_state)
        IDLE: begin
          if (!rx) begin
            w_stateNext  = DATA;
            w_bitIdxNext = '0;
          end
        end
        DATA: begin
          w_shiftNext[r_bitIdx] = rx;
          if (r_bitIdx == LAST_IDX) begin
            w_stateNext  = PARITY;
            w_bitIdxNext = '0;
          end else begin
            w_bitIdxNext = r_bitIdx + 1'b1;
          end
        end
        PARITY: begin
          w_parNext   = rx;
          w_stateNext = STOP;
        end
        STOP: begin
          w_stateNext = IDLE;
          w_frameDone = 1'b1;
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // Error counter: clear beats increment, and it sticks at all-ones.
  always_comb begin
    w_cntNext = r_errCnt;
    if (clr_cnt) begin
      w_cntNext = '0;
    end else if (w_frameDone && (w_parErr || w_frameErr) && (r_errCnt != CNT_MAX)) begin
      w_cntNext = r_errCnt + 1'b1;
    end
  end

  // Result registers: one-cycle valid pulse, flags only alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_parErr   <= 1'b0;
      r_frameErr <= 1'b0;
      r_errCnt   <= '0;
    end else begin
      r_valid    <= w_frameDone;
      r_parErr   <= w_frameDone & w_parErr;
      r_frameErr <= w_frameDone & w_frameErr;
      r_errCnt   <= w_cntNext;
      if (w_frameDone) begin
        r_data <= r_shift;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign par_err   = r_parErr;
  assign frame_err = r_frameErr;
  assign err_cnt   = r_errCnt;

endmodule
